tx_framer: RTL and testbench

TX_FRAMER -- requirements
Module: tx_framer

---
 rtl/tx_framer.sv | 155 +++++++++++++++
 tb/tb_tx_framer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_framer.sv
// ============================================================================
// Module      : tx_framer
// Description : Nibble-wide frame builder: preamble, SFD, PHR, then payload.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tx_framer #(
    parameter int          PREAMBLE_NIBBLES = 8,
    parameter logic [7:0]  SFD              = 8'hA7
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inStart,
    input  logic [6:0] inLength,
    input  logic [3:0] inPayload,
    input  logic       inPayloadValid,
    output logic       outPayloadReady,
    input  logic       inFifoFull,
    output logic       outFifoWriteEnable,
    output logic [3:0] outFifoData,
    output logic       outBusy,
    output logic       outDone,
    output logic       outError
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_SFD      = 3'd2;
    localparam logic [2:0] S_PHR      = 3'd3;
    localparam logic [2:0] S_PAYLOAD  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [7:0] c_PRE_LAST = 8'(PREAMBLE_NIBBLES - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] len_q, len_d;
    logic [7:0] w_pay_last;
    logic       w_write;

    assign w_pay_last = {len_q, 1'b0} - 8'd1;

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            len_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Each emitting state leaves on the edge that completes its last write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (inStart && (inLength != 7'd0)) begin
                    len_d   = inLength;
                    cnt_d   = 8'd0;
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (w_write) begin
                    if (cnt_q == c_PRE_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = S_SFD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_SFD, S_PHR: begin
                if (w_write) begin
                    if (cnt_q == 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = (state_q == S_SFD) ? S_PHR : S_PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_write) begin
                    if (cnt_q == w_pay_last) begin
                        cnt_d   = 8'd0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        outPayloadReady    = 1'b0;
        w_write            = 1'b0;
        outFifoData        = 4'h0;
        outBusy            = (state_q != S_IDLE);
        outDone            = (state_q == S_DONE);
        outError           = (state_q == S_IDLE) && inStart && (inLength == 7'd0);
        case (state_q)
            S_PREAMBLE: begin
                w_write = !inFifoFull;
            end
            S_SFD: begin
                w_write     = !inFifoFull;
                outFifoData = (cnt_q == 8'd0) ? SFD[3:0] : SFD[7:4];
            end
            S_PHR: begin
                w_write     = !inFifoFull;
                outFifoData = (cnt_q == 8'd0) ? len_q[3:0] : {1'b0, len_q[6:4]};
            end
            S_PAYLOAD: begin
                outPayloadReady = !inFifoFull;
                w_write         = inPayloadValid && !inFifoFull;
                outFifoData     = inPayload;
            end
            default: begin
                w_write = 1'b0;
            end
        endcase
        if (!w_write) begin
            outFifoData = 4'h0;
        end
        // Outputs are forced low combinationally while reset is held.
        if (!inReset) begin
            outPayloadReady = 1'b0;
            w_write         = 1'b0;
            outFifoData     = 4'h0;
            outBusy         = 1'b0;
            outDone         = 1'b0;
            outError        = 1'b0;
        end
        outFifoWriteEnable = w_write;
    end

endmodule

`default_nettype wire

// File: tb/tb_tx_framer.sv
// ============================================================================
// Module      : tb_tx_framer
// Description : Scoreboard bench for tx_framer with randomized host/FIFO timing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_tx_framer;

    localparam int         c_P   = 8;
    localparam logic [7:0] c_SFD = 8'hA7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] length = 7'd0;
    logic [3:0] pay = 4'h0;
    logic       pv = 1'b0;
    logic       full = 1'b0;
    logic       ready, we, busy, done, err;
    logic [3:0] fd;

    tx_framer #(.PREAMBLE_NIBBLES(c_P), .SFD(c_SFD)) dut (
        .inClock            (clk),
        .inReset            (rst_n),
        .inStart            (start),
        .inLength           (length),
        .inPayload          (pay),
        .inPayloadValid     (pv),
        .outPayloadReady    (ready),
        .inFifoFull         (full),
        .outFifoWriteEnable (we),
        .outFifoData        (fd),
        .outBusy            (busy),
        .outDone            (done),
        .outError           (err)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         frames_done = 0;
    logic [3:0] exp_q[$];
    logic [3:0] payload[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the expected nibble stream whenever the DUT writes.
    always @(negedge clk) begin
        if (rst_n) begin
            check("no_write_while_full", int'(we & full), 0);
            check("data_zero_without_write", (!we) ? int'(fd) : 0, 0);
            if (we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got data %0h with empty scoreboard", fd);
                end else begin
                    automatic logic [3:0] e = exp_q.pop_front();
                    if (fd != e) begin
                        errors++;
                        $display("FAIL fifo_data: got %0h expected %0h at %0t", fd, e, $time);
                    end
                end
            end
            if (done) begin
                check("scoreboard_empty_at_done", exp_q.size(), 0);
                frames_done++;
            end
        end
    end

    // Reference frame: preamble zeros, SFD low/high, PHR low/high, payload.
    task automatic push_expected(input int len);
        for (int i = 0; i < c_P; i++) exp_q.push_back(4'h0);
        exp_q.push_back(c_SFD[3:0]);
        exp_q.push_back(c_SFD[7:4]);
        exp_q.push_back(4'(len % 16));
        exp_q.push_back(4'(len / 16));
        for (int i = 0; i < payload.size(); i++) exp_q.push_back(payload[i]);
    endtask

    task automatic run_frame(input int len, input int full_pct, input int gap_pct,
                             input int stall_at, input int reset_at);
        int idx;
        int wr;
        int stall_left;
        int cyc;
        bit take;
        bit seen_done;
        idx = 0; wr = 0; stall_left = 5; cyc = 0; seen_done = 1'b0;
        if (payload.size() == 0)
            for (int i = 0; i < 2 * len; i++) payload.push_back(4'($urandom_range(15)));
        push_expected(len);
        @(posedge clk); #1;
        start  = 1'b1;
        length = 7'(len);
        full   = 1'b0;
        pv     = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 3000) begin
            pay    = (idx < payload.size()) ? payload[idx] : 4'($urandom_range(15));
            pv     = ($urandom_range(99) >= gap_pct);
            start  = ($urandom_range(15) == 0);
            length = 7'($urandom_range(127));
            if (stall_at >= 0 && wr == stall_at && stall_left > 0) begin
                full = 1'b1;
                stall_left--;
            end else begin
                full = ($urandom_range(99) < full_pct);
            end
            if (reset_at >= 0 && idx == reset_at && ready) begin
                pv = 1'b1;
                #1 rst_n = 1'b0;
                #1;
                check("rst_we", int'(we), 0);
                check("rst_data", int'(fd), 0);
                check("rst_ready", int'(ready), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                exp_q.delete();
                payload.delete();
                start = 1'b0;
                @(posedge clk); #1;
                check("rst_hold_busy", int'(busy), 0);
                check("rst_hold_done", int'(done), 0);
                rst_n = 1'b1;
                pv    = 1'b0;
                full  = 1'b0;
                return;
            end
            @(negedge clk);
            take = ready && pv;
            if (we) wr++;
            if (done) seen_done = 1'b1;
            @(posedge clk); #1;
            if (take) idx++;
            if (seen_done) break;
            cyc++;
        end
        check("frame_completed", int'(seen_done), 1);
        check("write_count", wr, c_P + 4 + 2 * len);
        check("payload_consumed", idx, 2 * len);
        start = 1'b0;
        full  = 1'b0;
        pv    = 1'b0;
        payload.delete();
    endtask

    task automatic error_test();
        @(posedge clk); #1;
        start  = 1'b1;
        length = 7'd0;
        #1;
        check("error_pulse", int'(err), 1);
        check("error_busy", int'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("error_cleared", int'(err), 0);
        check("error_still_idle", int'(busy), 0);
    endtask

    int expected_frames = 0;

    initial begin
        start  = 1'b1;
        length = 7'd0;
        #12;
        check("reset_err", int'(err), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_we", int'(we), 0);
        check("reset_ready", int'(ready), 0);
        check("reset_done", int'(done), 0);
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        payload.push_back(4'h5);
        payload.push_back(4'h3);
        run_frame(1, 0, 0, -1, -1);               expected_frames++;
        run_frame(127, 0, 0, -1, -1);             expected_frames++;
        run_frame(4, 0, 0, c_P + 1, -1);          expected_frames++;
        run_frame(10, 0, 50, -1, -1);             expected_frames++;
        error_test();
        for (int f = 0; f < 6; f++) begin
            run_frame(int'($urandom_range(1, 127)), 30, 30, -1, -1);
            expected_frames++;
        end
        run_frame(5, 0, 0, -1, 2);
        run_frame(3, 20, 20, -1, -1);             expected_frames++;
        repeat (3) @(posedge clk);
        #1;
        check("frames_done", frames_done, expected_frames);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
